fabric_stream_rx: RTL and testbench

//   Receiving end of a fabric_stream link.
//   - Sink side: a 2-entry skid buffer that registers in_ready, breaking the

---
 rtl/fabric_stream_rx.sv | 62 ++++++
 tb/tb_fabric_stream_rx.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/fabric_stream_rx.sv
// fabric_stream_rx: 2-entry skid-buffered stream sink with registered ready and sticky handshake checker
module fabric_stream_rx #(
  parameter int          WIDTH        = 32,
  parameter bit          CHECK_EN     = 1'b1,
  parameter int          ERR_W        = 16,
  parameter int unsigned ERR_DROP     = 1,
  parameter int unsigned ERR_UNSTABLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             error_valid,
  output logic [ERR_W-1:0] error_code
);
  logic [WIDTH-1:0] main_q, main_d, skid_q, skid_d, cap_q;
  logic [1:0]       cnt_q, cnt_d;
  logic             in_ready_q, stall_q, err_v_q, err_v_d, push, pop, viol;
  logic [ERR_W-1:0] err_c_q, err_c_d;
  assign in_ready    = in_ready_q;
  assign out_valid   = cnt_q != 2'd0;
  assign out_data    = main_q;
  assign error_valid = err_v_q;
  assign error_code  = err_c_q;
  always_comb begin
    push    = in_valid && in_ready_q;
    pop     = out_valid && out_ready;
    cnt_d   = cnt_q + {1'b0, push} - {1'b0, pop};
    main_d  = (pop && cnt_q == 2'd2) ? skid_q :
              (push && (cnt_q == 2'd0 || pop)) ? in_data : main_q;
    skid_d  = (push && ((cnt_q == 2'd1 && !pop) || (cnt_q == 2'd2 && pop))) ? in_data : skid_q;
    // a beat refused last edge must be held, unchanged, on this edge
    viol    = CHECK_EN && stall_q && !err_v_q && (!in_valid || in_data != cap_q);
    err_v_d = err_v_q || viol;
    err_c_d = viol ? (!in_valid ? ERR_W'(ERR_DROP) : ERR_W'(ERR_UNSTABLE)) : err_c_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      cap_q      <= '0;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
      stall_q    <= 1'b0;
      err_v_q    <= 1'b0;
      err_c_q    <= '0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      cap_q      <= in_data;
      cnt_q      <= cnt_d;
      in_ready_q <= cnt_d < 2'd2;
      stall_q    <= in_valid && !in_ready_q;
      err_v_q    <= err_v_d;
      err_c_q    <= err_c_d;
    end
  end
endmodule

// File: tb/tb_fabric_stream_rx.sv
// tb_fabric_stream_rx: directed and random stimulus against a queue-based reference model
module tb_fabric_stream_rx;
  logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready, out_valid, error_valid, in_ready0, out_valid0, error_valid0;
  logic [31:0] out_data, out_data0;
  logic [15:0] error_code, error_code0;
  int          errors = 0, checks = 0;
  logic [31:0] q[$];
  logic [31:0] cap_m, last_m;
  logic [15:0] errc_m;
  bit          rdy_m, stall_m, errv_m;

  always #5 clk = ~clk;

  fabric_stream_rx #(.WIDTH(32), .CHECK_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .error_valid(error_valid), .error_code(error_code));

  fabric_stream_rx #(.WIDTH(32), .CHECK_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .error_valid(error_valid0), .error_code(error_code0));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset;
    q.delete();
    rdy_m = 0; stall_m = 0; errv_m = 0; errc_m = '0; last_m = '0; cap_m = '0;
  endtask

  task automatic model_edge;
    bit push, pop;
    if (rst) begin
      model_reset();
      return;
    end
    push = in_valid && rdy_m;
    pop  = q.size() != 0 && out_ready;
    if (!errv_m && stall_m && (!in_valid || in_data != cap_m)) begin
      errv_m = 1;
      errc_m = !in_valid ? 16'd1 : 16'd2;
    end
    stall_m = in_valid && !rdy_m;
    cap_m   = in_data;
    if (pop) void'(q.pop_front());
    if (push) q.push_back(in_data);
    rdy_m = q.size() < 2;
    if (q.size() != 0) last_m = q[0];
  endtask

  task automatic check_outs;
    chk("in_ready", {31'b0, in_ready}, {31'b0, rdy_m});
    chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
    chk("out_data", out_data, last_m);
    chk("error_valid", {31'b0, error_valid}, {31'b0, errv_m});
    chk("error_code", {16'b0, error_code}, {16'b0, errc_m});
    chk("nc_in_ready", {31'b0, in_ready0}, {31'b0, rdy_m});
    chk("nc_out_valid", {31'b0, out_valid0}, {31'b0, q.size() != 0});
    chk("nc_out_data", out_data0, last_m);
    chk("nc_error", {15'b0, error_valid0, error_code0}, 32'd0);
  endtask

  task automatic step(input bit v, input logic [31:0] d, input bit r);
    in_valid = v; in_data = d; out_ready = r;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outs();
  endtask

  initial begin
    model_reset();
    repeat (3) begin
      step(0, 0, 0);
      chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    end
    rst = 1'b0;
    #1 chk("rel_in_ready_before_edge", {31'b0, in_ready}, 32'd0);
    step(0, 0, 0);
    chk("rel_in_ready", {31'b0, in_ready}, 32'd1);
    for (int i = 1; i <= 16; i++) begin
      step(1, i, 1);
      chk("stream_data", out_data, i);
      chk("stream_ready", {31'b0, in_ready}, 32'd1);
    end
    step(0, 0, 1);
    chk("stream_drained", {31'b0, out_valid}, 32'd0);
    step(1, 32'hA1, 0);
    step(1, 32'hA2, 0);
    chk("full_ready", {31'b0, in_ready}, 32'd0);
    chk("full_head", out_data, 32'hA1);
    step(0, 0, 1);
    chk("order_second", out_data, 32'hA2);
    chk("ready_again", {31'b0, in_ready}, 32'd1);
    step(0, 0, 1);
    step(1, 32'hE1, 0);
    step(1, 32'hE2, 0);
    step(1, 32'hB0, 0);
    step(0, 0, 0);
    chk("drop_valid", {31'b0, error_valid}, 32'd1);
    chk("drop_code", {16'b0, error_code}, 32'd1);
    step(1, 32'hB1, 0);
    step(1, 32'hB2, 0);
    chk("drop_sticky", {16'b0, error_code}, 32'd1);
    chk("data_unaltered", out_data, 32'hE1);
    rst = 1'b1;
    step(0, 0, 0);
    rst = 1'b0;
    step(0, 0, 0);
    step(1, 32'hF1, 0);
    step(1, 32'hF2, 0);
    step(1, 32'hC0, 0);
    step(1, 32'hC1, 0);
    chk("unstable_valid", {31'b0, error_valid}, 32'd1);
    chk("unstable_code", {16'b0, error_code}, 32'd2);
    chk("nocheck_valid", {31'b0, error_valid0}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("async_out_valid", {31'b0, out_valid}, 32'd0);
    chk("async_in_ready", {31'b0, in_ready}, 32'd0);
    chk("async_err_valid", {31'b0, error_valid}, 32'd0);
    chk("async_err_code", {16'b0, error_code}, 32'd0);
    chk("async_out_data", out_data, 32'd0);
    model_reset();
    step(0, 0, 0);
    rst = 1'b0;
    step(0, 0, 0);
    step(1, 32'hD0, 1);
    chk("post_rst_first", out_data, 32'hD0);
    chk("post_rst_valid", {31'b0, out_valid}, 32'd1);
    for (int i = 0; i < 3000; i++) begin
      bit          v;
      logic [31:0] d;
      rst = ($urandom_range(0, 299) == 0);
      v = $urandom_range(0, 3) != 0;
      d = $urandom;
      if (in_valid && !in_ready && $urandom_range(0, 3) != 0) begin
        v = 1;
        d = in_data;
      end
      step(v, d, $urandom_range(0, 1) == 1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
